// File: rtl/fazyrv_alu_pkg.sv
// Shared ALU op codes, control-line bundle and op decoder for the FazyRV ALU and its sequencer.
package fazyrv_alu_pkg;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_LT   = 4'd3,
    ALU_LTU  = 4'd4,
    ALU_EQ   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic sel_arith;
    logic en_a;
    logic op_sub;
    logic op_xor;
    logic op_and;
    logic cmp_signd;
    logic cmp_eq;
    logic cmp_keep;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Unused codes fall through to PASS so a stray op can never enable compare logic.
  function automatic alu_ctrl_t decode_alu_op(alu_op_e op);
    alu_ctrl_t c;
    c = '0;
    case (op)
      ALU_ADD: begin c.sel_arith = 1'b1; c.en_a = 1'b1; end
      ALU_SUB: begin c.sel_arith = 1'b1; c.en_a = 1'b1; c.op_sub = 1'b1; end
      ALU_LT:  begin c.en_a = 1'b1; c.cmp_signd = 1'b1; end
      ALU_LTU: c.en_a = 1'b1;
      ALU_EQ:  begin c.en_a = 1'b1; c.cmp_eq = 1'b1; end
      ALU_XOR: begin c.en_a = 1'b1; c.op_xor = 1'b1; end
      ALU_OR:  c.en_a = 1'b1;
      ALU_AND: begin c.en_a = 1'b1; c.op_and = 1'b1; end
      default: c.sel_arith = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fazyrv_alu_seq_if.sv
// Request/response channel between an issuing core and the chunked ALU sequencer.
interface fazyrv_alu_seq_if;
  import fazyrv_alu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_rs_a;
  logic [31:0] req_rs_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_cmp;

  modport master (
    output req_valid, req_op, req_rs_a, req_rs_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_cmp
  );

  modport slave (
    input  req_valid, req_op, req_rs_a, req_rs_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_cmp
  );
endinterface

// File: rtl/fazyrv_alu_seq.sv
// Streams a 32-bit operand pair through the ALU CHUNKSIZE bits per cycle, LSB first, and reassembles the result.
// Latency: lsb chunk one cycle after accept, response after ITERATIONS+1; a held response stalls new requests.
module fazyrv_alu_seq
  import fazyrv_alu_pkg::*;
#(
  parameter int CHUNKSIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  fazyrv_alu_seq_if.slave      bus,
  output logic                 lsb_o,
  output logic                 msb_o,
  output logic [CHUNKSIZE-1:0] rs_a_o,
  output logic [CHUNKSIZE-1:0] rs_b_o,
  input  logic [CHUNKSIZE-1:0] res_i,
  input  logic                 cmp_i,
  output logic                 sel_arith_o,
  output logic                 en_a_o,
  output logic                 op_sub_o,
  output logic                 op_xor_o,
  output logic                 op_and_o,
  output logic                 cmp_signd_o,
  output logic                 cmp_eq_o,
  output logic                 cmp_keep_o
);

  localparam int ITERATIONS = 32 / CHUNKSIZE;
  localparam int CNT_W      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  seq_state_e            state_q, state_d;
  logic [3:0]            op_q;
  logic [31:0]           a_q, b_q, res_q, rsp_res_q;
  logic                  rsp_cmp_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CHUNKSIZE+31:0] res_cat;
  alu_ctrl_t             ctrl;

  // Concatenate-then-shift keeps the CHUNKSIZE=32 case free of an empty slice.
  assign res_cat = {res_i, res_q} >> CHUNKSIZE;

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    lsb_o         = 1'b0;
    msb_o         = 1'b0;
    ctrl          = '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        lsb_o = (cnt_q == CNT_LAST);
        msb_o = (cnt_q == '0);
        ctrl  = decode_alu_op(alu_op_e'(op_q));
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      rsp_res_q <= '0;
      rsp_cmp_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q  <= bus.req_op;
            a_q   <= bus.req_rs_a;
            b_q   <= bus.req_rs_b;
            cnt_q <= CNT_LAST;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> CHUNKSIZE;
          b_q   <= b_q >> CHUNKSIZE;
          res_q <= res_cat[31:0];
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            rsp_res_q <= res_cat[31:0];
            rsp_cmp_q <= cmp_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign rs_a_o       = a_q[CHUNKSIZE-1:0];
  assign rs_b_o       = b_q[CHUNKSIZE-1:0];
  assign bus.rsp_res  = rsp_res_q;
  assign bus.rsp_cmp  = rsp_cmp_q;
  assign sel_arith_o  = ctrl.sel_arith;
  assign en_a_o       = ctrl.en_a;
  assign op_sub_o     = ctrl.op_sub;
  assign op_xor_o     = ctrl.op_xor;
  assign op_and_o     = ctrl.op_and;
  assign cmp_signd_o  = ctrl.cmp_signd;
  assign cmp_eq_o     = ctrl.cmp_eq;
  assign cmp_keep_o   = ctrl.cmp_keep;

endmodule

// File: tb/tb_fazyrv_alu_seq.sv
// Bench for fazyrv_alu_seq: an 8-bit-chunk and a 32-bit-chunk instance driven by a behavioural ALU model.
module tb_fazyrv_alu_seq;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // Control bits ordered {sel_arith,en_a,op_sub,op_xor,op_and,cmp_signd,cmp_eq,cmp_keep}, indexed by op code.
  localparam logic [7:0] DEC_TBL [0:15] = '{
    8'h80, 8'hC0, 8'hE0, 8'h44, 8'h40, 8'h42, 8'h50, 8'h40,
    8'h48, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80
  };

  fazyrv_alu_seq_if if8 ();
  fazyrv_alu_seq_if if32 ();

  logic        lsb8, msb8, cmp8;
  logic [7:0]  rsa8, rsb8, res8;
  logic        sel8, ena8, sub8, xor8, and8, sgn8, eq8, keep8;
  logic        lsb32, msb32, cmp32;
  logic [31:0] rsa32, rsb32, res32;
  logic        sel32, ena32, sub32, xor32, and32, sgn32, eq32, keep32;
  logic [7:0]  ctrl8, ctrl32;

  assign ctrl8  = {sel8, ena8, sub8, xor8, and8, sgn8, eq8, keep8};
  assign ctrl32 = {sel32, ena32, sub32, xor32, and32, sgn32, eq32, keep32};

  fazyrv_alu_seq #(.CHUNKSIZE(8)) dut8 (
    .clk_i(clk), .rst_in(rst_n), .bus(if8.slave),
    .lsb_o(lsb8), .msb_o(msb8), .rs_a_o(rsa8), .rs_b_o(rsb8), .res_i(res8), .cmp_i(cmp8),
    .sel_arith_o(sel8), .en_a_o(ena8), .op_sub_o(sub8), .op_xor_o(xor8), .op_and_o(and8),
    .cmp_signd_o(sgn8), .cmp_eq_o(eq8), .cmp_keep_o(keep8)
  );

  fazyrv_alu_seq #(.CHUNKSIZE(32)) dut32 (
    .clk_i(clk), .rst_in(rst_n), .bus(if32.slave),
    .lsb_o(lsb32), .msb_o(msb32), .rs_a_o(rsa32), .rs_b_o(rsb32), .res_i(res32), .cmp_i(cmp32),
    .sel_arith_o(sel32), .en_a_o(ena32), .op_sub_o(sub32), .op_xor_o(xor32), .op_and_o(and32),
    .cmp_signd_o(sgn32), .cmp_eq_o(eq32), .cmp_keep_o(keep32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // What the downstream ALU would return for a whole operation.
  task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic c);
    c = 1'($urandom);
    case (op)
      4'd0: r = b;
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: begin r = a - b; c = ($signed(a) < $signed(b)); end
      4'd4: begin r = a - b; c = (a < b); end
      4'd5: begin r = a - b; c = (a == b); end
      4'd6: r = a ^ b;
      4'd7: r = a | b;
      4'd8: r = a & b;
      default: r = $urandom;
    endcase
  endtask

  task automatic run_op8(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ec;
    logic [7:0]  ectl;
    alu_model(op, a, b, er, ec);
    ectl = DEC_TBL[op];
    n_cmp++;
    if ({if8.req_ready, if8.rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL %s idle_hs: got %b want 10", tag, {if8.req_ready, if8.rsp_valid});
    end
    if8.req_valid = 1'b1; if8.req_op = op; if8.req_rs_a = a; if8.req_rs_b = b; if8.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if8.req_valid = 1'b0;
      n_cmp++;
      if ({lsb8, msb8, ctrl8, if8.req_ready, if8.rsp_valid} !== {k == 0, k == 3, ectl, 2'b00}) begin
        n_err++;
        $display("FAIL %s run_flags k=%0d: got %b want %b", tag, k,
                 {lsb8, msb8, ctrl8, if8.req_ready, if8.rsp_valid}, {k == 0, k == 3, ectl, 2'b00});
      end
      n_cmp++;
      if ({rsa8, rsb8} !== {a[k*8 +: 8], b[k*8 +: 8]}) begin
        n_err++;
        $display("FAIL %s chunk k=%0d: got %h want %h", tag, k, {rsa8, rsb8}, {a[k*8 +: 8], b[k*8 +: 8]});
      end
      res8 = er[k*8 +: 8];
      cmp8 = (k == 3) ? ec : ~ec;
    end
    @(negedge clk);
    res8 = 8'($urandom);
    cmp8 = 1'($urandom);
    for (int h = 0; h <= hold; h++) begin
      n_cmp++;
      if ({lsb8, msb8, ctrl8, if8.req_ready, if8.rsp_valid, if8.rsp_res, if8.rsp_cmp} !==
          {10'd0, 2'b01, er, ec}) begin
        n_err++;
        $display("FAIL %s done h=%0d: got flags %b res %h cmp %b want res %h cmp %b", tag, h,
                 {lsb8, msb8, ctrl8, if8.req_ready, if8.rsp_valid}, if8.rsp_res, if8.rsp_cmp, er, ec);
      end
      if (h < hold) begin
        if8.req_valid = 1'b1; if8.req_op = 4'($urandom_range(15));
        if8.req_rs_a = $urandom; if8.req_rs_b = $urandom;
        @(negedge clk);
      end
    end
    if8.rsp_ready = 1'b1;
    @(negedge clk);
    if8.rsp_ready = 1'b0;
    n_cmp++;
    if ({if8.req_ready, if8.rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL %s back_idle: got %b want 10", tag, {if8.req_ready, if8.rsp_valid});
    end
  endtask

  task automatic run_op32(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] er;
    logic        ec;
    alu_model(op, a, b, er, ec);
    if32.req_valid = 1'b1; if32.req_op = op; if32.req_rs_a = a; if32.req_rs_b = b; if32.rsp_ready = 1'b0;
    @(negedge clk);
    if32.req_valid = 1'b0;
    n_cmp++;
    if ({lsb32, msb32, ctrl32, if32.req_ready, if32.rsp_valid, rsa32, rsb32} !==
        {2'b11, DEC_TBL[op], 2'b00, a, b}) begin
      n_err++;
      $display("FAIL %s run32: got %b %h %h want %b %h %h", tag,
               {lsb32, msb32, ctrl32, if32.req_ready, if32.rsp_valid}, rsa32, rsb32,
               {2'b11, DEC_TBL[op], 2'b00}, a, b);
    end
    res32 = er;
    cmp32 = ec;
    @(negedge clk);
    res32 = $urandom;
    cmp32 = ~ec;
    n_cmp++;
    if ({lsb32, msb32, ctrl32, if32.req_ready, if32.rsp_valid, if32.rsp_res, if32.rsp_cmp} !==
        {10'd0, 2'b01, er, ec}) begin
      n_err++;
      $display("FAIL %s done32: got res %h cmp %b vld %b want res %h cmp %b", tag,
               if32.rsp_res, if32.rsp_cmp, if32.rsp_valid, er, ec);
    end
    if32.rsp_ready = 1'b1;
    @(negedge clk);
    if32.rsp_ready = 1'b0;
    n_cmp++;
    if ({if32.req_ready, if32.rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL %s idle32: got %b want 10", tag, {if32.req_ready, if32.rsp_valid});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if8.req_valid = 1'b0; if8.req_op = '0; if8.req_rs_a = '0; if8.req_rs_b = '0; if8.rsp_ready = 1'b0;
    if32.req_valid = 1'b0; if32.req_op = '0; if32.req_rs_a = '0; if32.req_rs_b = '0; if32.rsp_ready = 1'b0;
    res8 = '0; cmp8 = 1'b0; res32 = '0; cmp32 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if8.req_ready, if8.rsp_valid, if8.rsp_res, if8.rsp_cmp, lsb8, msb8, ctrl8, rsa8, rsb8} !==
        {2'b10, 32'd0, 1'b0, 2'b00, 8'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset8: got rdy %b vld %b res %h cmp %b flags %b %h", if8.req_ready, if8.rsp_valid,
               if8.rsp_res, if8.rsp_cmp, {lsb8, msb8, ctrl8}, {rsa8, rsb8});
    end
    n_cmp++;
    if ({if32.req_ready, if32.rsp_valid, if32.rsp_res, if32.rsp_cmp, lsb32, msb32, ctrl32} !==
        {2'b10, 32'd0, 1'b0, 2'b00, 8'd0}) begin
      n_err++;
      $display("FAIL reset32: got rdy %b vld %b res %h flags %b", if32.req_ready, if32.rsp_valid,
               if32.rsp_res, {lsb32, msb32, ctrl32});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op8("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    n_cmp++;
    if (if8.rsp_res !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL add_wrap_res: got %h want 00000000", if8.rsp_res);
    end
    run_op8("sub", 4'd2, 32'h0000_0000, 32'h0000_0001, 0);
    n_cmp++;
    if (if8.rsp_res !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sub_res: got %h want ffffffff", if8.rsp_res);
    end
    run_op8("lt", 4'd3, 32'h8000_0000, 32'h0000_0001, 0);
    n_cmp++;
    if (if8.rsp_cmp !== 1'b1) begin
      n_err++;
      $display("FAIL lt_cmp: got %b want 1", if8.rsp_cmp);
    end
    run_op8("ltu", 4'd4, 32'h8000_0000, 32'h0000_0001, 0);
    n_cmp++;
    if (if8.rsp_cmp !== 1'b0) begin
      n_err++;
      $display("FAIL ltu_cmp: got %b want 0", if8.rsp_cmp);
    end
    run_op8("eq", 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    n_cmp++;
    if (if8.rsp_cmp !== 1'b1) begin
      n_err++;
      $display("FAIL eq_cmp: got %b want 1", if8.rsp_cmp);
    end
    run_op8("and", 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    n_cmp++;
    if (if8.rsp_res !== 32'hF000_F000) begin
      n_err++;
      $display("FAIL and_res: got %h want f000f000", if8.rsp_res);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(3) == 0) ? a : $urandom;
      run_op8("rand", 4'($urandom_range(15)), a, b, int'($urandom_range(2)));
    end
  endtask

  task automatic test_backpressure();
    run_op8("bp_hold", 4'd6, $urandom, $urandom, 10);
    run_op8("bp_next", 4'd7, $urandom, $urandom, 0);
  endtask

  task automatic test_reset_mid();
    if8.req_valid = 1'b1; if8.req_op = 4'd1; if8.req_rs_a = 32'h1234_5678; if8.req_rs_b = 32'h1111_1111;
    @(negedge clk);
    if8.req_valid = 1'b0;
    res8 = 8'h5A;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if8.req_ready, if8.rsp_valid, if8.rsp_res, if8.rsp_cmp, lsb8, msb8, ctrl8, rsa8, rsb8} !==
        {2'b10, 32'd0, 1'b0, 2'b00, 8'd0, 16'd0}) begin
      n_err++;
      $display("FAIL mid_reset: got rdy %b vld %b res %h cmp %b flags %b %h", if8.req_ready, if8.rsp_valid,
               if8.rsp_res, if8.rsp_cmp, {lsb8, msb8, ctrl8}, {rsa8, rsb8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({if8.req_ready, if8.rsp_valid, lsb8} !== 3'b100) begin
        n_err++;
        $display("FAIL post_reset i=%0d: got %b want 100", i, {if8.req_ready, if8.rsp_valid, lsb8});
      end
    end
    run_op8("after_reset", 4'd2, $urandom, $urandom, 1);
  endtask

  task automatic test_chunk32();
    run_op32("xor32", 4'd6, 32'h1234_5678, 32'hFFFF_FFFF);
    n_cmp++;
    if (if32.rsp_res !== 32'hEDCB_A987) begin
      n_err++;
      $display("FAIL xor32_res: got %h want edcba987", if32.rsp_res);
    end
    for (int i = 0; i < 8; i++) run_op32("rand32", 4'($urandom_range(15)), $urandom, $urandom);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_chunk32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fazyrv_alu_seq.md
Name: fazyrv_alu_seq

Overview:
Chunk sequencer that sits directly upstream of fazyrv_alu. It accepts a full 32-bit operand pair and an ALU op over a valid/ready request channel. It then streams the operands into the ALU CHUNKSIZE bits per cycle, LSB chunk first, driving lsb/msb framing and the decoded ALU control lines. It reassembles the result chunks and the final compare flag, and returns them over a valid/ready response channel.

Parameters:
CHUNKSIZE, 8, ALU datapath width per cycle; legal values 1, 2, 4, 8, 16, 32.
ITERATIONS, 32/CHUNKSIZE, chunks per operation; derived, not overridden.

Ports:
clk_i  in  1  clock, rising edge
rst_in  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_op_i  in  4  op code (alu_op_e)
req_rs_a_i  in  32  operand A
req_rs_b_i  in  32  operand B
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_res_o  out  32  assembled result
rsp_cmp_o  out  1  compare result
lsb_o  out  1  first chunk of the operation
msb_o  out  1  last chunk of the operation
rs_a_o  out  CHUNKSIZE  operand A chunk to ALU
rs_b_o  out  CHUNKSIZE  operand B chunk to ALU
res_i  in  CHUNKSIZE  result chunk from ALU (combinational, same cycle)
cmp_i  in  1  compare flag from ALU, valid in the msb cycle
sel_arith_o, en_a_o, op_sub_o, op_xor_o, op_and_o, cmp_signd_o, cmp_eq_o, cmp_keep_o  out  1 each  ALU control

Behaviour:
- Reset (async, rst_in=0): state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_res_o=0; rsp_cmp_o=0; lsb_o=msb_o=0; all control outputs 0; operand/result shift registers and chunk counter cleared. Reset asserted mid-RUN or mid-DONE aborts the operation; no response is produced.
- State IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch op, A and B; counter=ITERATIONS-1; go to RUN.
- State RUN (ITERATIONS cycles):
  - rs_a_o/rs_b_o = low CHUNKSIZE bits of the A/B shift registers.
  - lsb_o=1 iff counter==ITERATIONS-1. msb_o=1 iff counter==0. With ITERATIONS=1, both are high in the single cycle.
  - Each cycle: A and B shift right by CHUNKSIZE; res_i is shifted into the top of the result register ({res_i, res_r[31:CHUNKSIZE]}); counter decrements.
  - In the msb cycle: rsp_res_o <= {res_i, res_r[31:CHUNKSIZE]} (res_i alone for CHUNKSIZE=32); rsp_cmp_o <= cmp_i; go to DONE.
  - req_ready_o=0.
- State DONE:
  - rsp_valid_o=1; outputs stable.
  - On rsp_ready_i go to IDLE. No request is accepted in the same cycle; the next acceptance is one cycle later.
- lsb_o/msb_o are 0 outside RUN.
- Control outputs are decoded from the latched op and held constant through RUN; 0 in IDLE and DONE. cmp_keep_o is always 0.
- Decode table:
  - PASS: sel_arith.
  - ADD: sel_arith, en_a.
  - SUB: sel_arith, en_a, op_sub.
  - LT: en_a, cmp_signd.
  - LTU: en_a.
  - EQ: en_a, cmp_eq.
  - XOR: en_a, op_xor.
  - OR: en_a.
  - AND: en_a, op_and.
  - Codes 9..15 decode as PASS.
- Latency: request accepted at cycle t; lsb chunk at t+1; msb chunk at t+ITERATIONS; rsp_valid_o at t+ITERATIONS+1.
- Throughput: at most one operation per ITERATIONS+2 cycles with rsp_ready_i tied high.
- Response backpressure: DONE holds indefinitely while rsp_ready_i=0, with no change to rsp_res_o/rsp_cmp_o.
- Result width: the result is 32 bits; arithmetic wrap-around is produced by the ALU and passed through unmodified.

Decomposition:
- fazyrv_alu_pkg holds:
  - alu_op_e (PASS=0, ADD, SUB, LT, LTU, EQ, XOR, OR, AND; 4 bits).
  - alu_ctrl_t packed struct of the eight control bits.
  - Function decode_alu_op(alu_op_e) returning alu_ctrl_t; it is also used by the ALU formal bench.
- No sub-module. The decoder is the package function; the FSM, counter and shift registers stay in one module.

Test Plan:
- CHUNKSIZE=8, ADD A=0xFFFFFFFF B=0x00000001 -> lsb_o in cycle 1, msb_o in cycle 4, en_a_o=sel_arith_o=1 through RUN, rsp_valid_o in cycle 5, rsp_res_o=0x00000000.
- SUB A=0x00000000 B=0x00000001 -> rsp_res_o=0xFFFFFFFF; LT A=0x80000000 B=0x00000001 -> rsp_cmp_o=1; LTU with the same operands -> rsp_cmp_o=0.
- EQ A=B=0xDEADBEEF -> rsp_cmp_o=1; AND A=0xF0F0F0F0 B=0xFF00FF00 -> rsp_res_o=0xF000F000; rs_a_o sequence 0xF0,0xF0,0xF0,0xF0.
- CHUNKSIZE=32, XOR A=0x12345678 B=0xFFFFFFFF -> lsb_o=msb_o=1 in the same single cycle; rsp_res_o=0xEDCBA987 one cycle later.
- Backpressure: hold rsp_ready_i=0 for 10 cycles with req_valid_i=1 -> rsp_valid_o stays 1, req_ready_o stays 0, outputs unchanged; release -> IDLE, the next request is accepted one cycle later.
- Assert rst_in=0 during the second chunk -> all outputs return to reset values immediately; no rsp_valid_o after rst_in=1; next request completes normally.
